buffer_write: RTL and testbench

BUFFER_WRITE -- requirements
Module: buffer_write

---
 rtl/buffer_write.sv | 160 ++++++++++++++++
 tb/tb_buffer_write.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/buffer_write.sv
// Serial frame receiver that demultiplexes 2-bit payloads into four
// six-entry shift buffers with independent pop ports.
module buffer_write #(
  parameter int STOP_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic [3:0]  pop,
  output logic [17:0] buffer1_o,
  output logic [17:0] buffer2_o,
  output logic [17:0] buffer3_o,
  output logic [17:0] buffer4_o,
  output logic        busy,
  output logic        wr_done,
  output logic        drop,
  output logic        ferr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID1,
    S_ID0,
    S_D1,
    S_D0,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        w_busy;

  logic [1:0]  r_id;
  logic [1:0]  r_d;

  logic [17:0] r_buf    [4];
  logic [2:0]  r_occ    [4];
  logic [17:0] w_buf_nx [4];
  logic [2:0]  w_occ_nx [4];
  logic [3:0]  w_pop;
  logic [3:0]  w_push;
  logic [3:0]  w_wr;
  logic [3:0]  w_drop;

  logic        w_stop_edge;
  logic        w_stop_bad;
  logic        w_frame_ok;
  logic        w_ferr;

  // stop bit of 1 is a framing error only when checking is enabled
  assign w_stop_edge = (r_state == S_STOP);
  assign w_stop_bad  = (STOP_CHECK != 0) && bit_in;
  assign w_frame_ok  = w_stop_edge && !w_stop_bad;
  assign w_ferr      = w_stop_edge && w_stop_bad;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // FSM next state: only IDLE waits, every other state advances
  always_comb begin
    w_state_nx = S_IDLE;
    unique case (r_state)
      S_IDLE:  w_state_nx = bit_in ? S_ID1 : S_IDLE;
      S_ID1:   w_state_nx = S_ID0;
      S_ID0:   w_state_nx = S_D1;
      S_D1:    w_state_nx = S_D0;
      S_D0:    w_state_nx = S_STOP;
      S_STOP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  assign busy = w_busy;

  // capture id and data bits as they stream in
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id <= 2'b00;
      r_d  <= 2'b00;
    end else begin
      case (r_state)
        S_ID1:   r_id[1] <= bit_in;
        S_ID0:   r_id[0] <= bit_in;
        S_D1:    r_d[1]  <= bit_in;
        S_D0:    r_d[0]  <= bit_in;
        default: ;
      endcase
    end
  end

  // per-buffer update: pop shift first, then push into first free slot
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_buf_nx[k] = r_buf[k];
      w_occ_nx[k] = r_occ[k];
      w_pop[k]    = pop[k] && (r_occ[k] != 3'd0);
      w_push[k]   = w_frame_ok && (r_id == 2'(k));
      w_wr[k]     = 1'b0;
      w_drop[k]   = 1'b0;
      if (w_pop[k]) begin
        w_buf_nx[k] = {3'b000, r_buf[k][17:3]};
        w_occ_nx[k] = r_occ[k] - 3'd1;
      end
      if (w_push[k]) begin
        if (w_occ_nx[k] == 3'd6) begin
          w_drop[k] = 1'b1;
        end else begin
          w_wr[k] = 1'b1;
          for (int s = 0; s < 6; s++) begin
            if (w_occ_nx[k] == 3'(s))
              w_buf_nx[k][3*s +: 3] = {r_d, 1'b1};
          end
          w_occ_nx[k] = w_occ_nx[k] + 3'd1;
        end
      end
    end
  end

  // buffer contents and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_buf[k] <= '0;
        r_occ[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_buf[k] <= w_buf_nx[k];
        r_occ[k] <= w_occ_nx[k];
      end
    end
  end

  // one-cycle status pulses; only one buffer is targeted per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_done <= 1'b0;
      drop    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      wr_done <= |w_wr;
      drop    <= |w_drop;
      ferr    <= w_ferr;
    end
  end

  assign buffer1_o = r_buf[0];
  assign buffer2_o = r_buf[1];
  assign buffer3_o = r_buf[2];
  assign buffer4_o = r_buf[3];

endmodule

// File: tb/tb_buffer_write.sv
// Directed bench for buffer_write: writes, fill/drop, pops,
// push+pop, framing errors, back-to-back frames, mid-frame reset.
module tb_buffer_write;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic [3:0]  pop;
  logic [17:0] buffer1_o;
  logic [17:0] buffer2_o;
  logic [17:0] buffer3_o;
  logic [17:0] buffer4_o;
  logic        busy;
  logic        wr_done;
  logic        drop;
  logic        ferr;

  int n_chk;
  int n_err;

  buffer_write #(.STOP_CHECK(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .pop       (pop),
    .buffer1_o (buffer1_o),
    .buffer2_o (buffer2_o),
    .buffer3_o (buffer3_o),
    .buffer4_o (buffer4_o),
    .busy      (busy),
    .wr_done   (wr_done),
    .drop      (drop),
    .ferr      (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // inputs change on the falling edge; DUT samples on the rising edge
  task automatic send_frame(input logic [1:0] id,
                            input logic [1:0] d,
                            input logic       stop,
                            input logic [3:0] popv);
    @(negedge clk); bit_in = 1'b1; pop = 4'b0000;
    @(negedge clk); bit_in = id[1];
    @(negedge clk); bit_in = id[0];
    @(negedge clk); bit_in = d[1];
    @(negedge clk); bit_in = d[0];
    @(negedge clk); bit_in = stop; pop = popv;
  endtask

  task automatic idle();
    @(negedge clk); bit_in = 1'b0; pop = 4'b0000;
  endtask

  task automatic flags(input string tag,
                       input logic w, input logic dr, input logic fe);
    chk({tag, ".wr_done"}, 32'(wr_done), 32'(w));
    chk({tag, ".drop"},    32'(drop),    32'(dr));
    chk({tag, ".ferr"},    32'(ferr),    32'(fe));
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst    = 1'b1;
    bit_in = 1'b0;
    pop    = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst.buf1", 32'(buffer1_o), 32'h0);
    chk("rst.buf2", 32'(buffer2_o), 32'h0);
    chk("rst.buf3", 32'(buffer3_o), 32'h0);
    chk("rst.buf4", 32'(buffer4_o), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // single write: id 10, data 10 -> buffer3 slot0 = 101
    send_frame(2'b10, 2'b10, 1'b0, 4'b0000);
    idle();
    chk("single.buf3", 32'(buffer3_o), 32'h5);
    chk("single.busy", 32'(busy), 32'h0);
    flags("single", 1'b1, 1'b0, 1'b0);
    idle();
    flags("single.after", 1'b0, 1'b0, 1'b0);

    // fill buffer1 with six 011 entries, seventh frame is dropped
    for (int i = 0; i < 6; i++) begin
      send_frame(2'b00, 2'b01, 1'b0, 4'b0000);
      idle();
      chk("fill.wr", 32'(wr_done), 32'h1);
    end
    chk("fill.buf1", 32'(buffer1_o), 32'({6{3'b011}}));
    send_frame(2'b00, 2'b01, 1'b0, 4'b0000);
    idle();
    flags("full", 1'b0, 1'b1, 1'b0);
    chk("full.buf1", 32'(buffer1_o), 32'({6{3'b011}}));
    idle();
    chk("full.drop_pulse", 32'(drop), 32'h0);

    // buffer2: 011 then 101, pop once, pop again, pop on empty
    send_frame(2'b01, 2'b01, 1'b0, 4'b0000);
    send_frame(2'b01, 2'b10, 1'b0, 4'b0000);
    idle();
    chk("b2b.buf2", 32'(buffer2_o), 32'h2B);
    pop = 4'b0010;
    idle();
    chk("pop1.buf2", 32'(buffer2_o), 32'h5);
    flags("pop1", 1'b0, 1'b0, 1'b0);
    pop = 4'b0010;
    idle();
    chk("pop2.buf2", 32'(buffer2_o), 32'h0);
    pop = 4'b0010;
    idle();
    chk("popempty.buf2", 32'(buffer2_o), 32'h0);
    flags("popempty", 1'b0, 1'b0, 1'b0);
    idle();
    chk("popempty.buf1", 32'(buffer1_o), 32'({6{3'b011}}));

    // simultaneous pops on buffer1 and buffer3
    pop = 4'b0101;
    idle();
    chk("multipop.buf1", 32'(buffer1_o), 32'({3'b000, {5{3'b011}}}));
    chk("multipop.buf3", 32'(buffer3_o), 32'h0);

    // buffer4 full of 111, then push data 00 with a same-cycle pop
    for (int i = 0; i < 6; i++) begin
      send_frame(2'b11, 2'b11, 1'b0, 4'b0000);
    end
    idle();
    chk("fill4.buf4", 32'(buffer4_o), 32'({6{3'b111}}));
    send_frame(2'b11, 2'b00, 1'b0, 4'b1000);
    idle();
    chk("pushpop.buf4", 32'(buffer4_o), 32'({3'b001, {5{3'b111}}}));
    flags("pushpop", 1'b1, 1'b0, 1'b0);

    // framing error: stop bit 1 discards the frame
    send_frame(2'b00, 2'b10, 1'b1, 4'b0000);
    idle();
    flags("ferr", 1'b0, 1'b0, 1'b1);
    chk("ferr.buf1", 32'(buffer1_o), 32'({3'b000, {5{3'b011}}}));
    chk("ferr.busy", 32'(busy), 32'h0);
    send_frame(2'b01, 2'b11, 1'b0, 4'b0000);
    idle();
    chk("ferr.next.buf2", 32'(buffer2_o), 32'h7);
    flags("ferr.next", 1'b1, 1'b0, 1'b0);

    // reset during D1 aborts the frame and clears everything
    @(negedge clk); bit_in = 1'b1;
    @(negedge clk); bit_in = 1'b0;
    @(negedge clk); bit_in = 1'b1;
    @(negedge clk); bit_in = 1'b1;
    chk("midrst.busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; bit_in = 1'b0;
    chk("midrst.busy", 32'(busy), 32'h0);
    chk("midrst.buf1", 32'(buffer1_o), 32'h0);
    chk("midrst.buf2", 32'(buffer2_o), 32'h0);
    chk("midrst.buf3", 32'(buffer3_o), 32'h0);
    chk("midrst.buf4", 32'(buffer4_o), 32'h0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("midrst.nowr", 32'(wr_done), 32'h0);
    end
    chk("midrst.buf2.late", 32'(buffer2_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
